// File: rtl/awg_pkg.sv
// Shared definitions for the AWG command controller: packet constants,
// opcode table, payload field mapping, the live/shadow configuration record
// and the state encodings of the byte reader and the packet parser.
package awg_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WAVE_W  = 5;
  localparam int unsigned FREQ_W  = 12;
  localparam int unsigned AMP_W   = 3;
  localparam int unsigned PHASE_W = 8;
  localparam int unsigned IDX_W   = 3;

  localparam logic [BYTE_W-1:0] HDR_BYTE  = 8'hA5;
  localparam logic [BYTE_W-1:0] OPC_WAVE  = 8'h01;
  localparam logic [BYTE_W-1:0] OPC_FREQ  = 8'h02;
  localparam logic [BYTE_W-1:0] OPC_AMP   = 8'h03;
  localparam logic [BYTE_W-1:0] OPC_PHASE = 8'h04;
  localparam logic [BYTE_W-1:0] OPC_ALL   = 8'h05;

  // Configuration record driven to sig_gen (also used for the shadow copy).
  typedef struct packed {
    logic [WAVE_W-1:0]  wave;
    logic [FREQ_W-1:0]  freq;
    logic [AMP_W-1:0]   amp;
    logic [PHASE_W-1:0] phase;
  } cfg_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOW,
    RD_SAMPLE,
    RD_HIGH
  } rd_state_t;

  typedef enum logic [1:0] {
    PS_HDR,
    PS_OPC,
    PS_PAY,
    PS_CSUM
  } parse_state_t;

  // Destination of one payload byte.
  typedef enum logic [2:0] {
    FLD_WAVE,
    FLD_FHI,
    FLD_FLO,
    FLD_AMP,
    FLD_PHASE,
    FLD_NONE
  } fld_t;

  function automatic logic opc_known(input logic [BYTE_W-1:0] opc);
    return (opc == OPC_WAVE) || (opc == OPC_FREQ) || (opc == OPC_AMP) ||
           (opc == OPC_PHASE) || (opc == OPC_ALL);
  endfunction

  // Payload length table; unknown opcodes report zero.
  function automatic logic [IDX_W-1:0] pay_len(input logic [BYTE_W-1:0] opc);
    case (opc)
      OPC_WAVE:  return 3'd1;
      OPC_FREQ:  return 3'd2;
      OPC_AMP:   return 3'd1;
      OPC_PHASE: return 3'd1;
      OPC_ALL:   return 3'd5;
      default:   return 3'd0;
    endcase
  endfunction

  // Maps (opcode, payload index) to the shadow field it writes.
  function automatic fld_t pay_field(input logic [BYTE_W-1:0] opc,
                                     input logic [IDX_W-1:0]  idx);
    case (opc)
      OPC_WAVE:  return FLD_WAVE;
      OPC_FREQ:  return (idx == 3'd0) ? FLD_FHI : FLD_FLO;
      OPC_AMP:   return FLD_AMP;
      OPC_PHASE: return FLD_PHASE;
      OPC_ALL: begin
        case (idx)
          3'd0:    return FLD_WAVE;
          3'd1:    return FLD_FHI;
          3'd2:    return FLD_FLO;
          3'd3:    return FLD_AMP;
          default: return FLD_PHASE;
        endcase
      end
      default:   return FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ft245_rd_if.sv
// FT245 read-side byte reader. Waits for rxf_n low, drives rd_n low for
// RD_WAIT cycles, latches d_in in the following cycle (rd_n already high),
// then holds rd_n high for RD_HOLD cycles before looking at rxf_n again.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   rxf_n, d_in   - FT245 FIFO not-empty (active low) and data bus
//   rd_n          - FT245 read strobe (active low, registered)
//   byte_data     - last byte read
//   byte_vld      - one-cycle strobe, byte_data valid
module ft245_rd_if
  import awg_pkg::*;
#(
  parameter int unsigned RD_WAIT = 3,
  parameter int unsigned RD_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxf_n,
  input  logic [BYTE_W-1:0] d_in,
  output logic              rd_n,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_vld
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RD_HOLD - 1);

  rd_state_t        state;
  logic [CNT_W-1:0] cnt;

  // Reader FSM; rd_n is released on the same edge that leaves RD_LOW.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RD_IDLE;
      rd_n      <= 1'b1;
      cnt       <= '0;
      byte_data <= '0;
      byte_vld  <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (!rxf_n) begin
            state <= RD_LOW;
            rd_n  <= 1'b0;
            cnt   <= '0;
          end
        end
        RD_LOW: begin
          if (cnt == WAIT_LAST) begin
            state <= RD_SAMPLE;
            rd_n  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RD_SAMPLE: begin
          byte_data <= d_in;
          byte_vld  <= 1'b1;
          cnt       <= '0;
          state     <= RD_HIGH;
        end
        RD_HIGH: begin
          if (cnt == HOLD_LAST) begin
            state <= RD_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= RD_IDLE;
          rd_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/awg_cmd_ctrl.sv
// AWG command controller: reads bytes from an FT245 FIFO and parses
// A5 / opcode / payload / XOR-checksum packets into the sig_gen settings.
// Payload lands in a shadow copy; the addressed fields move to the outputs
// together only when the checksum matches.
// Optional build macro AWG_CMD_CTRL_TIMEOUT_EN: abandon a partial packet
// (with cmd_err) after TIMEOUT idle cycles between bytes.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   rxf_n, d_in     - FT245 FIFO not-empty and data bus
//   rd_n            - FT245 read strobe
//   wave_sel, freq_word, amp_sel, phase_off - settings to sig_gen
//   cfg_upd         - pulse one cycle after the settings change
//   cmd_err         - pulse on a rejected packet
//   busy            - packet partially received
module awg_cmd_ctrl
  import awg_pkg::*;
#(
  parameter logic [WAVE_W-1:0] DEF_WAVE = 5'd3,
  parameter int unsigned       RD_WAIT  = 3,
  parameter int unsigned       RD_HOLD  = 2,
  parameter logic [15:0]       TIMEOUT  = 16'd50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxf_n,
  input  logic [BYTE_W-1:0]  d_in,
  output logic               rd_n,
  output logic [WAVE_W-1:0]  wave_sel,
  output logic [FREQ_W-1:0]  freq_word,
  output logic [AMP_W-1:0]   amp_sel,
  output logic [PHASE_W-1:0] phase_off,
  output logic               cfg_upd,
  output logic               cmd_err,
  output logic               busy
);

  logic [BYTE_W-1:0] byte_data;
  logic              byte_vld;

  ft245_rd_if #(
    .RD_WAIT (RD_WAIT),
    .RD_HOLD (RD_HOLD)
  ) u_rd (
    .clk       (clk),
    .rst       (rst),
    .rxf_n     (rxf_n),
    .d_in      (d_in),
    .rd_n      (rd_n),
    .byte_data (byte_data),
    .byte_vld  (byte_vld)
  );

  parse_state_t      state;
  logic [BYTE_W-1:0] opc;
  logic [IDX_W-1:0]  idx;
  logic [BYTE_W-1:0] csum;
  cfg_t              shadow;
  cfg_t              cfg;
  logic              upd_pend;
  logic              tmo_hit_c;

`ifdef AWG_CMD_CTRL_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign tmo_hit_c = busy && !byte_vld && (idle_cnt == (TIMEOUT - 16'd1));

  // Idle-cycle counter, only running while a packet is open.
  always_ff @(posedge clk) begin
    if (rst || byte_vld || !busy || tmo_hit_c) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  logic [15:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign tmo_hit_c      = 1'b0;
`endif

  // Packet parser; busy is kept in step with every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PS_HDR;
      busy     <= 1'b0;
      opc      <= '0;
      idx      <= '0;
      csum     <= '0;
      shadow   <= '0;
      cfg      <= '{wave: DEF_WAVE, freq: '0, amp: '0, phase: '0};
      upd_pend <= 1'b0;
      cfg_upd  <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err  <= 1'b0;
      upd_pend <= 1'b0;
      cfg_upd  <= upd_pend;
      if (byte_vld) begin
        case (state)
          PS_HDR: begin
            if (byte_data == HDR_BYTE) begin
              state <= PS_OPC;
              busy  <= 1'b1;
            end
          end
          PS_OPC: begin
            if (!opc_known(byte_data)) begin
              cmd_err <= 1'b1;
              state   <= PS_HDR;
              busy    <= 1'b0;
            end else begin
              opc  <= byte_data;
              csum <= byte_data;
              idx  <= '0;
              state <= (pay_len(byte_data) == 3'd0) ? PS_CSUM : PS_PAY;
            end
          end
          PS_PAY: begin
            csum <= csum ^ byte_data;
            case (pay_field(opc, idx))
              FLD_WAVE:  shadow.wave       <= byte_data[WAVE_W-1:0];
              FLD_FHI:   shadow.freq[11:8] <= byte_data[3:0];
              FLD_FLO:   shadow.freq[7:0]  <= byte_data;
              FLD_AMP:   shadow.amp        <= byte_data[AMP_W-1:0];
              FLD_PHASE: shadow.phase      <= byte_data;
              default: ;
            endcase
            if (idx == (pay_len(opc) - 3'd1)) begin
              state <= PS_CSUM;
            end else begin
              idx <= idx + 3'd1;
            end
          end
          PS_CSUM: begin
            state <= PS_HDR;
            busy  <= 1'b0;
            if (byte_data == csum) begin
              // Only the fields this opcode addresses are committed.
              case (opc)
                OPC_WAVE:  cfg.wave  <= shadow.wave;
                OPC_FREQ:  cfg.freq  <= shadow.freq;
                OPC_AMP:   cfg.amp   <= shadow.amp;
                OPC_PHASE: cfg.phase <= shadow.phase;
                OPC_ALL:   cfg       <= shadow;
                default: ;
              endcase
              upd_pend <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          default: begin
            state <= PS_HDR;
            busy  <= 1'b0;
          end
        endcase
      end else if (tmo_hit_c) begin
        cmd_err <= 1'b1;
        state   <= PS_HDR;
        busy    <= 1'b0;
      end
    end
  end

  assign wave_sel  = cfg.wave;
  assign freq_word = cfg.freq;
  assign amp_sel   = cfg.amp;
  assign phase_off = cfg.phase;

endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// Scoreboard bench for awg_cmd_ctrl. An FT245 FIFO model feeds bytes; each
// packet pushes its expected event (update or error, plus resulting
// settings) into a queue that a monitor drains on cfg_upd/cmd_err.
// Define AWG_CMD_CTRL_TIMEOUT_EN to also exercise the idle timeout.
module tb_awg_cmd_ctrl;

  localparam logic [4:0]  DEF_WAVE = 5'd3;
  localparam int unsigned RD_WAIT  = 3;
  localparam int unsigned RD_HOLD  = 2;
  localparam logic [15:0] TIMEOUT  = 16'd100;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxf_n;
  logic [7:0]  d_in;
  logic        rd_n;
  logic [4:0]  wave_sel;
  logic [11:0] freq_word;
  logic [2:0]  amp_sel;
  logic [7:0]  phase_off;
  logic        cfg_upd;
  logic        cmd_err;
  logic        busy;

  awg_cmd_ctrl #(
    .DEF_WAVE (DEF_WAVE),
    .RD_WAIT  (RD_WAIT),
    .RD_HOLD  (RD_HOLD),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxf_n     (rxf_n),
    .d_in      (d_in),
    .rd_n      (rd_n),
    .wave_sel  (wave_sel),
    .freq_word (freq_word),
    .amp_sel   (amp_sel),
    .phase_off (phase_off),
    .cfg_upd   (cfg_upd),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  w;
    logic [11:0] f;
    logic [2:0]  a;
    logic [7:0]  p;
  } cfg_m_t;

  typedef struct {
    bit     is_err;
    cfg_m_t cfg;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] tx_q[$];
  logic [7:0] pay_buf[5];
  cfg_m_t     model;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         in_rst_test = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int len_of(input logic [7:0] op);
    case (op)
      8'h01: return 1;
      8'h02: return 2;
      8'h03: return 1;
      8'h04: return 1;
      8'h05: return 5;
      default: return -1;
    endcase
  endfunction

  // Effect of a good packet on the settings, straight from the opcode table.
  function automatic cfg_m_t apply(input cfg_m_t m, input logic [7:0] op);
    cfg_m_t r;
    r = m;
    case (op)
      8'h01: r.w = pay_buf[0][4:0];
      8'h02: r.f = {pay_buf[0][3:0], pay_buf[1]};
      8'h03: r.a = pay_buf[0][2:0];
      8'h04: r.p = pay_buf[0];
      8'h05: begin
        r.w = pay_buf[0][4:0];
        r.f = {pay_buf[1][3:0], pay_buf[2]};
        r.a = pay_buf[3][2:0];
        r.p = pay_buf[4];
      end
      default: ;
    endcase
    return r;
  endfunction

  // Queue one packet and its expected outcome.
  task automatic send_pkt(input logic [7:0] op, input bit corrupt);
    int         n;
    logic [7:0] cs;
    exp_t       e;
    n = len_of(op);
    tx_q.push_back(8'hA5);
    tx_q.push_back(op);
    cs = op;
    if (n < 0) begin
      e.is_err = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        tx_q.push_back(pay_buf[i]);
        cs = cs ^ pay_buf[i];
      end
      if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
      tx_q.push_back(cs);
      e.is_err = corrupt;
      if (!corrupt) model = apply(model, op);
    end
    e.cfg = model;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(tx_q.size() == 0 && sb.size() == 0 && !busy && rd_n) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: timed out, tx=%0d sb=%0d busy=%0b", tx_q.size(), sb.size(), busy);
    end
    repeat (RD_HOLD + 6) @(negedge clk);
  endtask

  // FT245 FIFO model: present the head byte while rd_n is low, pop on release.
  logic prev_rd_n = 1'b1;
  always @(negedge clk) begin
    if (prev_rd_n && !rd_n && tx_q.size() > 0) d_in = tx_q[0];
    if (!prev_rd_n && rd_n && tx_q.size() > 0) void'(tx_q.pop_front());
    prev_rd_n = rd_n;
    rxf_n = (tx_q.size() == 0);
  end

  // rd_n timing monitor.
  int low_run = 0;
  int high_run = 0;
  bit seen_read = 1'b0;
  logic prev_m = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      low_run = 0;
      high_run = 0;
      seen_read = 1'b0;
      prev_m = 1'b1;
    end else begin
      if (!rd_n) begin
        if (prev_m) begin
          if (seen_read) chk("rd_n_high_gap_ge_hold", 32'(high_run >= int'(RD_HOLD)), 32'd1);
          low_run = 0;
        end
        low_run++;
      end else begin
        if (!prev_m) begin
          chk("rd_n_low_width", 32'(low_run), 32'(RD_WAIT));
          seen_read = 1'b1;
          high_run = 0;
        end
        high_run++;
      end
      prev_m = rd_n;
    end
  end

  // Scoreboard monitor.
  cfg_m_t cur;
  cfg_m_t prev_cfg;
  bit     changed_last = 1'b0;
  exp_t   e_m;
  always @(negedge clk) begin
    cur = '{w: wave_sel, f: freq_word, a: amp_sel, p: phase_off};
    if (!rst && !in_rst_test) begin
      if (cfg_upd || cmd_err) chk("upd_err_exclusive", 32'(cfg_upd && cmd_err), 32'd0);
      if (changed_last) chk("cfg_upd_after_change", 32'(cfg_upd), 32'd1);
      if (cfg_upd || cmd_err) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: cfg_upd=%0b cmd_err=%0b at %0t", cfg_upd, cmd_err, $time);
        end else begin
          e_m = sb.pop_front();
          chk("event_is_err", 32'(cmd_err), 32'(e_m.is_err));
          chk(e_m.is_err ? "outputs_after_err" : "outputs_after_upd", 32'(cur), 32'(e_m.cfg));
          if (!e_m.is_err) chk("outputs_lead_cfg_upd", 32'(prev_cfg), 32'(e_m.cfg));
        end
      end
      changed_last = (cur != prev_cfg);
    end else begin
      changed_last = 1'b0;
    end
    prev_cfg = cur;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    int         r;
    logic [7:0] op;
    logic [7:0] j;
    rst = 1'b1;
    rxf_n = 1'b1;
    d_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_rd_n", 32'(rd_n), 32'd1);
    chk("reset_wave", 32'(wave_sel), 32'(DEF_WAVE));
    chk("reset_freq", 32'(freq_word), 32'd0);
    chk("reset_amp", 32'(amp_sel), 32'd0);
    chk("reset_phase", 32'(phase_off), 32'd0);
    chk("reset_cfg_upd", 32'(cfg_upd), 32'd0);
    chk("reset_cmd_err", 32'(cmd_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    model = '{w: DEF_WAVE, f: 12'h0, a: 3'h0, p: 8'h0};
    rst = 1'b0;
    @(negedge clk);

    // A5 02 03 E8 E9
    pay_buf[0] = 8'h03; pay_buf[1] = 8'hE8;
    send_pkt(8'h02, 1'b0);
    wait_idle();
    chk("dir_freq_3e8", 32'(freq_word), 32'h3E8);
    chk("dir_freq_wave_kept", 32'(wave_sel), 32'(DEF_WAVE));

    // A5 05 07 0F FF 05 80 + checksum
    pay_buf[0] = 8'h07; pay_buf[1] = 8'h0F; pay_buf[2] = 8'hFF;
    pay_buf[3] = 8'h05; pay_buf[4] = 8'h80;
    send_pkt(8'h05, 1'b0);
    wait_idle();
    chk("dir_all_cfg", 32'({wave_sel, freq_word, amp_sel, phase_off}),
        32'({5'd7, 12'hFFF, 3'd5, 8'h80}));

    // Bad checksum on amp, then a good one
    pay_buf[0] = 8'h04;
    send_pkt(8'h03, 1'b1);
    wait_idle();
    chk("dir_badcs_amp_kept", 32'(amp_sel), 32'd5);
    pay_buf[0] = 8'hFE;
    send_pkt(8'h03, 1'b0);
    wait_idle();
    chk("dir_amp_masked", 32'(amp_sel), 32'd6);

    // Leading junk then unknown opcode 09
    tx_q.push_back(8'h00);
    tx_q.push_back(8'hFF);
    send_pkt(8'h09, 1'b0);
    wait_idle();

    // Randomized packet stream
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 5; i++) pay_buf[i] = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        send_pkt(8'($urandom_range(1, 5)), 1'b0);
      end else if (r == 6) begin
        send_pkt(8'($urandom_range(1, 5)), 1'b1);
      end else if (r == 7) begin
        do op = 8'($urandom); while (op >= 8'h01 && op <= 8'h05);
        send_pkt(op, 1'b0);
      end else begin
        for (int i = 0; i < $urandom_range(1, 3); i++) begin
          j = 8'($urandom);
          if (j == 8'hA5) j = 8'h00;
          tx_q.push_back(j);
        end
        send_pkt(8'($urandom_range(1, 5)), 1'b0);
      end
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();

    // Reset in the middle of a packet and a read
    in_rst_test = 1'b1;
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h03);
    k = 0;
    while (!(busy && !rd_n) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("midpkt_busy_seen", 32'(busy && !rd_n), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_releases_rd_n", 32'(rd_n), 32'd1);
    chk("rst_no_cmd_err", 32'(cmd_err), 32'd0);
    tx_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", 32'({wave_sel, freq_word, amp_sel, phase_off}),
        32'({DEF_WAVE, 12'h0, 3'h0, 8'h0}));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_err_after", 32'(cmd_err), 32'd0);
    model = '{w: DEF_WAVE, f: 12'h0, a: 3'h0, p: 8'h0};
    repeat (5) @(negedge clk);
    in_rst_test = 1'b0;

    pay_buf[0] = 8'h5A;
    send_pkt(8'h04, 1'b0);
    wait_idle();
    chk("post_rst_phase", 32'(phase_off), 32'h5A);

`ifdef AWG_CMD_CTRL_TIMEOUT_EN
    // A5 01 then stall: idle timeout abandons the packet
    begin
      exp_t et;
      et.is_err = 1'b1;
      et.cfg = model;
      sb.push_back(et);
      tx_q.push_back(8'hA5);
      tx_q.push_back(8'h01);
      wait_idle();
      chk("timeout_busy_low", 32'(busy), 32'd0);
    end
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
